// File: rtl/ni_pkg.sv
// Shared definitions for the network-interface receive DMA.
//   ni_state_t     : receive FSM states
//   FLIT_SIZE_LSB/MSB : payload-length field inside the size flit
//   WB_WORD        : byte-enable pattern for a full 32-bit word write
package ni_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    SIZE    = 3'd2,
    PAYLOAD = 3'd3,
    DONE    = 3'd4
  } ni_state_t;

  localparam int FLIT_SIZE_LSB = 0;
  localparam int FLIT_SIZE_MSB = 15;
  localparam int LEN_W         = FLIT_SIZE_MSB - FLIT_SIZE_LSB + 1;

  localparam logic [3:0] WB_WORD = 4'b1111;

endpackage

// File: rtl/ni_recv_dma.sv
// Receive DMA: takes packet flits from the router port and writes the payload
// into the node RAM's second port, one word per accepted flit.
//
// Packet: header flit, size flit ([15:0] = N words), N payload flits.
//
// Ports
//   clock, reset         : rising-edge clock, async active-low reset
//   flit_valid_in/data_in: router flit offer; flit_ready_out accepts it
//   start_in/base_addr_in: CPU arm pulse and destination byte address
//   busy_out, done_out   : armed/receiving flag, one-cycle completion pulse
//   header_out, length_out, overflow_out : status of the last packet
//   mem_enable_out, mem_wb_out, mem_addr_out, mem_data_out : RAM write port
//
// Every output is a flop. Write strobe follows the accept edge by one cycle;
// done_out follows the final accept by two cycles so the last word is already
// in RAM when software sees it.
module ni_recv_dma
  import ni_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH       = 16,
  parameter int MAX_WORDS        = 256
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flit_valid_in,
  input  logic [MEMORY_BUS_WIDTH-1:0] flit_data_in,
  output logic                        flit_ready_out,
  input  logic                        start_in,
  input  logic [ADDR_WIDTH-1:0]       base_addr_in,
  output logic                        busy_out,
  output logic                        done_out,
  output logic [MEMORY_BUS_WIDTH-1:0] header_out,
  output logic [LEN_W-1:0]            length_out,
  output logic                        overflow_out,
  output logic                        mem_enable_out,
  output logic [3:0]                  mem_wb_out,
  output logic [ADDR_WIDTH-1:0]       mem_addr_out,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out
);

  // Store limit widened by one bit so MAX_WORDS = 2^LEN_W still compares right.
  localparam logic [LEN_W:0] MAX_W = (LEN_W+1)'(MAX_WORDS);

  ni_state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]       base_q, base_d;
  logic [LEN_W-1:0]            cnt_q, cnt_d;
  logic [MEMORY_BUS_WIDTH-1:0] hdr_q, hdr_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic                        ovf_q, ovf_d;
  logic                        ready_q, ready_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        en_q, en_d;
  logic [3:0]                  wb_q, wb_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [MEMORY_BUS_WIDTH-1:0] data_q, data_d;

  logic                        acc;
  logic                        in_range;
  logic [ADDR_WIDTH-1:0]       word_off;
  logic [LEN_W-1:0]            size_fld;

  assign acc      = flit_valid_in && ready_q;
  assign in_range = {1'b0, cnt_q} < MAX_W;
  // Byte offset of word i; truncation to ADDR_WIDTH gives the silent wrap.
  assign word_off = ADDR_WIDTH'({cnt_q, 2'b00});
  assign size_fld = flit_data_in[FLIT_SIZE_MSB:FLIT_SIZE_LSB];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    en_d    = 1'b0;
    wb_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          base_d  = {base_addr_in[ADDR_WIDTH-1:2], 2'b00};
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (acc) begin
          hdr_d   = flit_data_in;
          state_d = SIZE;
        end
      end
      SIZE: begin
        if (acc) begin
          len_d   = size_fld;
          state_d = (size_fld == '0) ? DONE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (acc) begin
          cnt_d = cnt_q + 1'b1;
          if (in_range) begin
            en_d   = 1'b1;
            wb_d   = WB_WORD;
            addr_d = base_q + word_off;
            data_d = flit_data_in;
          end else begin
            // Excess words are still consumed so the router drains the packet.
            ovf_d = 1'b1;
          end
          if (cnt_q == len_q - 1'b1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs are derived from the next state so they line up with it.
    ready_d = (state_d == HDR) || (state_d == SIZE) || (state_d == PAYLOAD);
    // busy stays up through the done pulse and drops with it.
    busy_d  = (state_d != IDLE) || (state_q == DONE);
    done_d  = (state_q == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      wb_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      wb_q    <= wb_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign flit_ready_out = ready_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign header_out     = hdr_q;
  assign length_out     = len_q;
  assign overflow_out   = ovf_q;
  assign mem_enable_out = en_q;
  assign mem_wb_out     = wb_q;
  assign mem_addr_out   = addr_q;
  assign mem_data_out   = data_q;

endmodule

// File: tb/tb_ni_recv_dma.sv
// Scoreboard bench for ni_recv_dma (MAX_WORDS = 4 so overflow is reachable).
// The driver pushes expected writes / completions as flits are accepted; an
// independent monitor pops and compares whenever the DUT strobes a write or
// raises done_out.
module tb_ni_recv_dma;

  localparam int AW   = 16;
  localparam int MAXW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flit_valid_in = 1'b0;
  logic [31:0] flit_data_in = '0;
  logic        flit_ready_out;
  logic        start_in = 1'b0;
  logic [15:0] base_addr_in = '0;
  logic        busy_out, done_out, overflow_out;
  logic [31:0] header_out;
  logic [15:0] length_out;
  logic        mem_enable_out;
  logic [3:0]  mem_wb_out;
  logic [15:0] mem_addr_out;
  logic [31:0] mem_data_out;

  ni_recv_dma #(.MEMORY_BUS_WIDTH(32), .ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset),
    .flit_valid_in(flit_valid_in), .flit_data_in(flit_data_in),
    .flit_ready_out(flit_ready_out),
    .start_in(start_in), .base_addr_in(base_addr_in),
    .busy_out(busy_out), .done_out(done_out),
    .header_out(header_out), .length_out(length_out), .overflow_out(overflow_out),
    .mem_enable_out(mem_enable_out), .mem_wb_out(mem_wb_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] h; logic [15:0] l; logic o; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  logic [7:0] ram [int];
  int total = 0;
  int bad   = 0;
  int wcnt  = 0;
  logic [31:0] pl[$];   // payload for the next packet

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every strobe / done pulse against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_enable_out) begin
        wcnt++;
        for (int b = 0; b < 4; b++)
          ram[(int'(mem_addr_out) + b) % 65536] = mem_data_out[31-8*b -: 8];
        chk("wr_wb", mem_wb_out, 4'b1111);
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", mem_addr_out, e.a);
          chk("wr_data", mem_data_out, e.d);
        end
      end else if (mem_wb_out != 4'b0) begin
        chk("wb_idle", mem_wb_out, 0);
      end
      if (done_out) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          dn_t e;
          e = dq.pop_front();
          chk("done_hdr", header_out, e.h);
          chk("done_len", length_out, e.l);
          chk("done_ovf", overflow_out, e.o);
        end
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_ready", flit_ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_en", mem_enable_out, 0);
    chk("rst_wb", mem_wb_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_data", mem_data_out, 0);
    chk("rst_hdr", header_out, 0);
    chk("rst_len", length_out, 0);
    chk("rst_ovf", overflow_out, 0);
  endtask

  // Arm, then stream header/size/payload. abort_at >= 0 asserts reset after
  // that many payload words have been accepted.
  task automatic run_pkt(input logic [15:0] base, input logic [31:0] hdr,
                         input int n, input bit bp, input int abort_at);
    logic [31:0] fl[$];
    int idx, cyc, budget;
    bit acc, prev_acc;
    fl.push_back(hdr);
    fl.push_back({16'($urandom), 16'(n)});
    for (int i = 0; i < n; i++) fl.push_back(pl[i]);

    @(negedge clock);
    start_in = 1'b1;
    base_addr_in = base;
    @(negedge clock);
    start_in = 1'b0;
    chk("arm_ready", flit_ready_out, 1);
    chk("arm_busy", busy_out, 1);
    chk("arm_ovf_clr", overflow_out, 0);

    idx = 0; cyc = 0; prev_acc = 1'b1; budget = 20 * (n + 2) + 50;
    while (1) begin
      if (bp) begin
        if (prev_acc || !flit_valid_in) flit_valid_in = 1'($urandom % 2);
      end else flit_valid_in = 1'b1;
      flit_data_in = fl[idx];
      acc = flit_valid_in && flit_ready_out;
      if (!bp && idx == 0) chk("hdr_next_cycle", acc, 1);
      @(posedge clock);
      if (acc) begin
        if (idx >= 2) begin
          int p;
          p = idx - 2;
          if (p < MAXW) begin
            wr_t w;
            w.a = 16'(((int'(base) & 32'hFFFC) + 4 * p) % 65536);
            w.d = fl[idx];
            wq.push_back(w);
          end
        end
        idx++;
        if (abort_at >= 0 && idx - 2 == abort_at) begin
          @(negedge clock);
          flit_valid_in = 1'b0;
          @(posedge clock);
          #1 reset = 1'b0;
          #1 chk_reset_vals();
          @(negedge clock);
          chk("abort_no_done", done_out, 0);
          @(negedge clock);
          reset = 1'b1;
          return;
        end
        if (idx == fl.size()) break;
      end
      prev_acc = acc;
      cyc++;
      if (cyc > budget) begin
        chk("timeout", 1, 0);
        @(negedge clock);
        flit_valid_in = 1'b0;
        return;
      end
      @(negedge clock);
    end
    begin
      dn_t d;
      d.h = hdr; d.l = 16'(n); d.o = (n > MAXW);
      dq.push_back(d);
    end
    @(negedge clock);
    flit_valid_in = 1'b0;
    chk("done_early", done_out, 0);
    @(negedge clock);
    chk("done_pulse", done_out, 1);
    chk("done_busy", busy_out, 1);
    chk("done_no_strobe", mem_enable_out, 0);
    @(negedge clock);
    chk("done_one_cycle", done_out, 0);
    chk("idle_busy", busy_out, 0);
    chk("idle_ready", flit_ready_out, 0);
    chk("hold_len", length_out, 16'(n));
    chk("hold_ovf", overflow_out, n > MAXW);
  endtask

  task automatic rand_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back($urandom);
  endtask

  initial begin
    int w0;
    #1 chk_reset_vals();
    #12 reset = 1'b1;

    // Basic packet
    pl = '{32'hAABBCCDD, 32'h11223344, 32'h55667788};
    run_pkt(16'h0100, 32'h00000011, 3, 1'b0, -1);
    chk("ram_100", ram[32'h100], 8'hAA);
    chk("ram_101", ram[32'h101], 8'hBB);
    chk("ram_102", ram[32'h102], 8'hCC);
    chk("ram_103", ram[32'h103], 8'hDD);
    chk("ram_108", ram[32'h108], 8'h55);

    // Flits offered while not armed
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      flit_valid_in = 1'b1;
      flit_data_in = 32'hDEAD0000;
      chk("idle_no_ready", flit_ready_out, 0);
    end
    rand_pl(2);
    run_pkt(16'h0200, 32'hDEAD0000, 2, 1'b0, -1);

    // Zero length
    w0 = wcnt;
    run_pkt(16'h0300, 32'h0000_0BAD, 0, 1'b0, -1);
    chk("zero_no_writes", wcnt - w0, 0);

    // Overflow: 6 words into a 4-word limit
    w0 = wcnt;
    rand_pl(6);
    run_pkt(16'h0400, 32'h0000_0F0F, 6, 1'b0, -1);
    chk("ovf_write_count", wcnt - w0, 4);

    // Wrap and alignment
    rand_pl(2);
    run_pkt(16'hFFFE, 32'h0000_AAAA, 2, 1'b0, -1);

    // Random packets under backpressure
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(0, 7);
      rand_pl(n);
      run_pkt(16'($urandom), $urandom, n, 1'b1, -1);
    end

    // Reset after 2 of 5 payload words, then a clean packet
    rand_pl(5);
    run_pkt(16'h0500, 32'h0000_5555, 5, 1'b0, 2);
    rand_pl(3);
    run_pkt(16'h0600, 32'h0000_6666, 3, 1'b1, -1);

    repeat (4) @(negedge clock);
    chk("wq_drained", wq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
